// File: rtl/alloc_register_banks.sv
// Banked scratch register file: each bank allocates its own write slot (lowest free)
// and tracks slot validity. Reads return data one cycle later and may free the slot.
// Latency: read data 1 cycle; wr_addr is combinational from the pre-edge valid map.
// No backpressure: pipe_en=0 freezes all state; writes to a full bank are dropped and flagged.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pipe_en             global advance enable
//   wr_en/wr_data       per-bank write request and data; wr_addr reports the slot used
//   rd_en/rd_inv/rd_addr per-bank read request, free-on-read, read slot
//   rd_data/rd_valid    registered read data and per-bank "updated last advance" flag
//   full/empty/occupancy per-bank fill status
//   err_overflow/err_rd_inv sticky error flags, cleared by err_clr (set wins)
module alloc_register_banks #(
  parameter int N_BANKS    = 4,
  parameter int BANK_DEPTH = 16,
  parameter int WORD_W     = 32,
  localparam int AW        = $clog2(BANK_DEPTH),
  localparam int CW        = $clog2(BANK_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pipe_en,
  input  logic [N_BANKS-1:0]          wr_en,
  input  logic [N_BANKS*WORD_W-1:0]   wr_data,
  output logic [N_BANKS*AW-1:0]       wr_addr,
  input  logic [N_BANKS-1:0]          rd_en,
  input  logic [N_BANKS-1:0]          rd_inv,
  input  logic [N_BANKS*AW-1:0]       rd_addr,
  output logic [N_BANKS*WORD_W-1:0]   rd_data,
  output logic [N_BANKS-1:0]          rd_valid,
  output logic [N_BANKS-1:0]          full,
  output logic [N_BANKS-1:0]          empty,
  output logic [N_BANKS*CW-1:0]       occupancy,
  output logic                        err_overflow,
  output logic                        err_rd_inv,
  input  logic                        err_clr
);

  logic [N_BANKS-1:0] ovf_set;
  logic [N_BANKS-1:0] bad_rd_set;

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [BANK_DEPTH-1:0] vmap;
    logic [WORD_W-1:0]     mem [BANK_DEPTH];
    logic [CW-1:0]         occ;
    logic [AW-1:0]         alloc;
    logic [AW-1:0]         ra;
    logic [WORD_W-1:0]     rd_q;
    logic                  rv_q;
    logic                  bank_full;
    logic                  slot_valid;
    logic                  wr_acc;
    logic                  inv_hit;

    assign ra         = rd_addr[b*AW +: AW];
    assign slot_valid = vmap[ra];
    assign bank_full  = (occ == CW'(BANK_DEPTH));
    assign wr_acc     = pipe_en & wr_en[b] & ~bank_full;
    // Only freeing a slot that was actually valid reduces the count.
    assign inv_hit    = pipe_en & rd_en[b] & rd_inv[b] & slot_valid;

    assign ovf_set[b]    = pipe_en & wr_en[b] & bank_full;
    assign bad_rd_set[b] = pipe_en & rd_en[b] & ~slot_valid;

    // Lowest free slot; scanning downward lets the lowest index win.
    // A full bank falls through to 0.
    always_comb begin
      alloc = '0;
      for (int i = BANK_DEPTH - 1; i >= 0; i--) begin
        if (!vmap[i]) alloc = AW'(i);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vmap <= '0;
        occ  <= '0;
        rd_q <= '0;
        rv_q <= 1'b0;
        for (int i = 0; i < BANK_DEPTH; i++) mem[i] <= '0;
      end else if (pipe_en) begin
        // Invalidate first, then write: if the freed slot is also the allocated
        // one (it was already free), the write's valid bit must win.
        if (rd_en[b] && rd_inv[b]) vmap[ra] <= 1'b0;
        if (wr_acc) begin
          vmap[alloc] <= 1'b1;
          mem[alloc]  <= wr_data[b*WORD_W +: WORD_W];
        end
        occ  <= occ + CW'(wr_acc) - CW'(inv_hit);
        rv_q <= rd_en[b];
        if (rd_en[b]) rd_q <= mem[ra];
      end
    end

    assign wr_addr[b*AW +: AW]       = alloc;
    assign rd_data[b*WORD_W +: WORD_W] = rd_q;
    assign rd_valid[b]               = rv_q;
    assign full[b]                   = bank_full;
    assign empty[b]                  = (occ == '0);
    assign occupancy[b*CW +: CW]     = occ;

    a_occ_matches_map: assert property (@(posedge clk) disable iff (rst)
      occ == CW'($countones(vmap)));
  end

  // Sticky errors: a new event in the same cycle beats err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow <= 1'b0;
      err_rd_inv   <= 1'b0;
    end else begin
      if (|ovf_set)         err_overflow <= 1'b1;
      else if (err_clr)     err_overflow <= 1'b0;
      if (|bad_rd_set)      err_rd_inv   <= 1'b1;
      else if (err_clr)     err_rd_inv   <= 1'b0;
    end
  end

  a_no_x_outputs: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({wr_addr, rd_data, rd_valid, full, empty, occupancy,
                 err_overflow, err_rd_inv}));

endmodule

// File: tb/tb_alloc_register_banks.sv
module tb_alloc_register_banks;
  localparam int NB = 4;
  localparam int BD = 4;
  localparam int WW = 32;
  localparam int AW = 2;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_en;
  logic [NB-1:0]     wr_en;
  logic [NB*WW-1:0]  wr_data;
  logic [NB*AW-1:0]  wr_addr;
  logic [NB-1:0]     rd_en;
  logic [NB-1:0]     rd_inv;
  logic [NB*AW-1:0]  rd_addr;
  logic [NB*WW-1:0]  rd_data;
  logic [NB-1:0]     rd_valid;
  logic [NB-1:0]     full;
  logic [NB-1:0]     empty;
  logic [NB*CW-1:0]  occupancy;
  logic              err_overflow;
  logic              err_rd_inv;
  logic              err_clr;

  alloc_register_banks #(.N_BANKS(NB), .BANK_DEPTH(BD), .WORD_W(WW)) dut (
    .clk(clk), .rst(rst), .pipe_en(pipe_en),
    .wr_en(wr_en), .wr_data(wr_data), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_inv(rd_inv), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .occupancy(occupancy),
    .err_overflow(err_overflow), .err_rd_inv(err_rd_inv), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          bank;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] waddr(input int b);
    return wr_addr[b*AW +: AW];
  endfunction

  function automatic logic [CW-1:0] occ(input int b);
    return occupancy[b*CW +: CW];
  endfunction

  function automatic logic [WW-1:0] rdat(input int b);
    return rd_data[b*WW +: WW];
  endfunction

  task automatic idle();
    pipe_en = 1'b1; wr_en = '0; wr_data = '0; rd_en = '0; rd_inv = '0;
    rd_addr = '0; err_clr = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_wr(input int b, input logic [31:0] d);
    wr_en[b] = 1'b1;
    wr_data[b*WW +: WW] = d;
  endtask

  task automatic set_rd(input int b, input logic [AW-1:0] a, input logic inv,
                        input logic [31:0] expect_data);
    rd_exp_t e;
    rd_en[b] = 1'b1;
    rd_inv[b] = inv;
    rd_addr[b*AW +: AW] = a;
    e.bank = b;
    e.data = expect_data;
    exp_q.push_back(e);
  endtask

  // Monitor: any bank whose rd_valid rose from an advancing edge must match
  // the oldest outstanding expectation.
  initial begin : monitor
    logic adv;
    rd_exp_t e;
    forever begin
      @(posedge clk);
      adv = pipe_en && !rst;
      @(negedge clk);
      if (adv) begin
        for (int b = 0; b < NB; b++) begin
          if (rd_valid[b]) begin
            if (exp_q.size() == 0) begin
              chk($sformatf("unexpected_rd_b%0d", b), 32'(b), 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("rd_bank_b%0d", b), 32'(b), 32'(e.bank));
              chk($sformatf("rd_data_b%0d", b), rdat(b), e.data);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] a_word [4];
    for (int i = 0; i < 4; i++) a_word[i] = 32'hA000_0000 + 32'(i);

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_empty", 32'(empty), 32'hF);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_rd_data0", rdat(0), 32'h0);
    chk("rst_errs", {30'b0, err_overflow, err_rd_inv}, 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);

    // Fill bank0.
    for (int i = 0; i < 4; i++) begin
      set_wr(0, a_word[i]);
      chk($sformatf("fill_wr_addr%0d", i), 32'(waddr(0)), 32'(i));
      cyc();
      idle();
    end
    chk("fill_full0", 32'(full[0]), 32'h1);
    chk("fill_occ0", 32'(occ(0)), 32'd4);
    chk("fill_empty0", 32'(empty[0]), 32'h0);

    // Overflow write.
    set_wr(0, 32'h0000_DEAD);
    chk("ovf_wr_addr", 32'(waddr(0)), 32'h0);
    cyc(); idle();
    chk("ovf_flag", 32'(err_overflow), 32'h1);
    chk("ovf_occ0", 32'(occ(0)), 32'd4);
    set_rd(0, 2'd0, 1'b0, a_word[0]);   // slot0 must be untouched
    cyc(); idle();

    // Read and free slot2.
    set_rd(0, 2'd2, 1'b1, a_word[2]);
    cyc(); idle();
    chk("inv_occ0", 32'(occ(0)), 32'd3);
    chk("inv_full0", 32'(full[0]), 32'h0);
    chk("inv_wr_addr", 32'(waddr(0)), 32'd2);
    set_wr(0, 32'hB0B0_0002);
    cyc(); idle();
    chk("refill_occ0", 32'(occ(0)), 32'd4);
    set_rd(0, 2'd2, 1'b0, 32'hB0B0_0002);
    cyc(); idle();
    chk("no_rdinv_yet", 32'(err_rd_inv), 32'h0);

    // Bank1: write and read of the same (still invalid) slot in one cycle.
    set_wr(1, 32'hC1C1_0001);
    set_rd(1, 2'd0, 1'b0, 32'h0);
    chk("b1_wr_addr", 32'(waddr(1)), 32'h0);
    cyc(); idle();
    chk("b1_rdinv_flag", 32'(err_rd_inv), 32'h1);
    chk("b1_occ", 32'(occ(1)), 32'd1);
    set_rd(1, 2'd0, 1'b0, 32'hC1C1_0001);
    cyc(); idle();

    // Freeze for 3 cycles with requests asserted; clear errors on the last.
    for (int i = 0; i < 3; i++) begin
      pipe_en = 1'b0; wr_en = '1; rd_en = '1; rd_inv = '1; rd_addr = '0;
      wr_data = {4{32'h5555_AAAA}};
      err_clr = (i == 2);
      cyc();
      chk($sformatf("frz_occ%0d", i), 32'(occupancy), {20'b0, 3'd0, 3'd0, 3'd1, 3'd4});
      chk($sformatf("frz_rdv%0d", i), 32'(rd_valid), 32'h2);
      chk($sformatf("frz_rd1_%0d", i), rdat(1), 32'hC1C1_0001);
      chk($sformatf("frz_rd0_%0d", i), rdat(0), 32'hB0B0_0002);
      chk($sformatf("frz_err%0d", i), {30'b0, err_overflow, err_rd_inv},
          (i == 2) ? 32'h0 : 32'h3);
    end
    idle();

    // Full bank: invalidate slot1 and write in the same cycle -> write dropped.
    set_wr(0, 32'h0000_EEEE);
    set_rd(0, 2'd1, 1'b1, a_word[1]);
    chk("fiw_wr_addr_pre", 32'(waddr(0)), 32'h0);
    cyc(); idle();
    chk("fiw_ovf", 32'(err_overflow), 32'h1);
    chk("fiw_rdinv", 32'(err_rd_inv), 32'h0);
    chk("fiw_occ0", 32'(occ(0)), 32'd3);
    chk("fiw_wr_addr_post", 32'(waddr(0)), 32'd1);

    // Reset mid-stream with a read in flight (its data is discarded).
    rst = 1'b1;
    rd_en = 4'b0001; rd_addr = '0;
    wr_en = 4'b0010; wr_data = {4{32'h7777_7777}};
    cyc();
    rst = 1'b0;
    idle();
    chk("mrst_occ", 32'(occupancy), 32'h0);
    chk("mrst_empty", 32'(empty), 32'hF);
    chk("mrst_rdv", 32'(rd_valid), 32'h0);
    chk("mrst_wr_addr", 32'(wr_addr), 32'h0);
    chk("mrst_errs", {30'b0, err_overflow, err_rd_inv}, 32'h0);

    // Slot data was cleared by reset.
    set_rd(0, 2'd0, 1'b0, 32'h0);
    cyc(); idle();
    chk("post_rst_rdinv", 32'(err_rd_inv), 32'h1);
    cyc();
    cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
